// File: rtl/uart_tx_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_stream_pkg
//  Purpose  : Shared UART definitions: FSM states, parity codes, baud
//             divisor and parity helpers. Kept separate so a matching
//             receiver can reuse them.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clocks per serial bit.
  function automatic int bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // Parity bit for a zero-extended payload; zero padding does not change XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD)  return ~p;
    if (mode == PARITY_EVEN) return p;
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Synchronous FIFO with registered read data. A pop loads the
//             head word into rdata_o on the same edge it is removed.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      level;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wptr_q - rptr_q;
  assign full_o  = (level == FULL_LEVEL);
  assign empty_o = (level == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign level_o = level;
  assign rdata_o = rdata_q;

  // Pointer update and registered read of the head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        rptr_q  <= rptr_q + 1'b1;
        rdata_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  // Storage array; contents need no reset because pointers gate access.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_stream
//  Purpose  : UART transmitter with input FIFO and valid/ready handshake.
//             Frames are sent back to back while the FIFO holds data.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_stream
  import uart_tx_stream_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_txd
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int BAUD_W  = $clog2(BPS_CNT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  // Reject unsupported frame formats at elaboration.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_stream: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_stream: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (BPS_CNT < 4) begin : g_bad_bps
    $error("uart_tx_stream: CLK_FREQ/UART_BPS must be >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   busy_q;

  logic                   fifo_full, fifo_empty, pop, baud_last;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [7:0]             par_word;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_ready  = ~fifo_full;
  assign tx_busy   = busy_q;
  assign uart_txd  = txd_q;
  assign baud_last = (baud_q == BAUD_LAST);

  // Zero-extend the popped word so the shared parity helper can be used.
  always_comb begin
    par_word = '0;
    par_word[DATA_BITS-1:0] = fifo_rdata;
  end

  // State, counters and line register; reset abandons any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= (state_q != ST_IDLE) || !fifo_empty;
    end
  end

  // Next-state logic: the popped word lands in the FIFO read register one
  // edge later, so the shifter is loaded on the first START clock and the
  // line register follows the state by one clock.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    txd_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (baud_q == '0) begin
          shift_d = fifo_rdata;
          par_d   = parity_bit(par_word, PARITY);
        end
        if (baud_last) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        txd_d = shift_q[0];
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            stop_d  = 1'b0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        txd_d = par_q;
        if (baud_last) begin
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (baud_last) begin
          if (stop_q == STOP_LAST) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_stream
//  Purpose  : Self-checking bench for uart_tx_stream across four frame
//             formats, comparing the serial line clock by clock against
//             frames built from the word, parity mode and stop count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_stream;

  localparam int BPS = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [4];
  logic [7:0] data  [4];
  logic       ready [4];
  logic       busy  [4];
  logic [4:0] level [4];
  logic       txd   [4];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 8O1   3: 5N2
  uart_tx_stream #(.CLK_FREQ(50000000), .UART_BPS(5000000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .fifo_level(level[0]), .uart_txd(txd[0]));
  uart_tx_stream #(.CLK_FREQ(50000000), .UART_BPS(5000000), .PARITY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .fifo_level(level[1]), .uart_txd(txd[1]));
  uart_tx_stream #(.CLK_FREQ(50000000), .UART_BPS(5000000), .PARITY(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .fifo_level(level[2]), .uart_txd(txd[2]));
  uart_tx_stream #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(5), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3][4:0]),
    .tx_ready(ready[3]), .tx_busy(busy[3]), .fifo_level(level[3]), .uart_txd(txd[3]));

  function automatic int cfg_db(input int k);  return (k == 3) ? 5 : 8; endfunction
  function automatic int cfg_par(input int k); return (k == 1) ? 2 : (k == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(input int k);  return (k == 3) ? 2 : 1; endfunction

  // One-cycle push; starts and ends on a falling edge.
  task automatic push_word(input int k, input logic [7:0] w);
    valid[k] = 1'b1;
    data[k]  = w;
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  // Build the expected frame from the word and compare every clock of it.
  // With need_fall, first waits (bounded) for the start bit; otherwise the
  // start bit must be on the line at the current falling edge.
  task automatic check_frame(input int k, input logic [7:0] w, input string tag, input bit need_fall);
    logic bits [$];
    logic p;
    int   t, bad_at;
    logic bad_v, bad_e;
    bits.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < cfg_db(k); i++) begin
      bits.push_back(w[i]);
      p = p ^ w[i];
    end
    if (cfg_par(k) == 1) bits.push_back(~p);
    if (cfg_par(k) == 2) bits.push_back(p);
    for (int i = 0; i < cfg_sb(k); i++) bits.push_back(1'b1);
    if (need_fall) begin
      t = 0;
      while (txd[k] !== 1'b0 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) begin
        compared++;
        mismatched++;
        $display("FAIL %s dut%0d: start bit never seen (got txd=%b, required 0)", tag, k, txd[k]);
        return;
      end
    end
    bad_at = -1;
    bad_v  = 1'b0;
    bad_e  = 1'b0;
    for (int c = 0; c < bits.size() * BPS; c++) begin
      if (bad_at < 0 && txd[k] !== bits[c / BPS]) begin
        bad_at = c;
        bad_v  = txd[k];
        bad_e  = bits[c / BPS];
      end
      @(negedge clk);
    end
    compared++;
    if (bad_at >= 0) begin
      mismatched++;
      $display("FAIL %s dut%0d word=%h: clk %0d of frame got txd=%b required %b",
               tag, k, w, bad_at, bad_v, bad_e);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (txd[k] !== 1'b1 || ready[k] !== 1'b1 || busy[k] !== 1'b0 || level[k] !== 5'd0) begin
        mismatched++;
        $display("FAIL reset dut%0d: got txd=%b ready=%b busy=%b level=%0d required 1 1 0 0",
                 k, txd[k], ready[k], busy[k], level[k]);
      end
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (txd[k] !== 1'b1 || busy[k] !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_after_reset dut%0d: got txd=%b busy=%b required 1 0", k, txd[k], busy[k]);
      end
    end
  endtask

  task automatic test_basic_frame();
    push_word(0, 8'hA5);
    compared++;
    if (level[0] !== 5'd1 || txd[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL latency_edge1: got level=%0d txd=%b required 1 1", level[0], txd[0]);
    end
    @(negedge clk);
    compared++;
    if (txd[0] !== 1'b1 || busy[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL latency_edge2: got txd=%b busy=%b required 1 1", txd[0], busy[0]);
    end
    @(negedge clk);
    compared++;
    if (txd[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_fall: got txd=%b required 0 two clocks after push", txd[0]);
    end
    check_frame(0, 8'hA5, "frame_a5", 1'b0);
    compared++;
    if (busy[0] !== 1'b0 || level[0] !== 5'd0) begin
      mismatched++;
      $display("FAIL busy_after_frame: got busy=%b level=%0d required 0 0", busy[0], level[0]);
    end
    for (int r = 0; r < 3; r++) begin
      logic [7:0] w;
      w = 8'($urandom);
      push_word(0, w);
      check_frame(0, w, "frame_rand8n1", 1'b1);
    end
  endtask

  task automatic test_parity();
    push_word(1, 8'h07);
    check_frame(1, 8'h07, "even_07", 1'b1);
    push_word(2, 8'h07);
    check_frame(2, 8'h07, "odd_07", 1'b1);
    for (int r = 0; r < 3; r++) begin
      logic [7:0] w;
      w = 8'($urandom);
      push_word(1, w);
      check_frame(1, w, "even_rand", 1'b1);
      w = 8'($urandom);
      push_word(2, w);
      check_frame(2, w, "odd_rand", 1'b1);
    end
  endtask

  task automatic test_short_two_stop();
    push_word(3, 8'h1F);
    check_frame(3, 8'h1F, "5n2_1f", 1'b1);
    for (int r = 0; r < 3; r++) begin
      logic [7:0] w;
      w = 8'($urandom_range(0, 31));
      push_word(3, w);
      check_frame(3, w, "5n2_rand", 1'b1);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_q [$];
    int  maxlvl;
    bit  rdy_bad;
    maxlvl  = 0;
    rdy_bad = 1'b0;
    fork
      begin
        int sent, cyc;
        logic [7:0] w;
        logic rdy;
        logic [4:0] lvl;
        sent = 0;
        cyc  = 0;
        w    = 8'($urandom);
        while (sent < 20 && cyc < 5000) begin
          valid[0] = 1'b1;
          data[0]  = w;
          rdy = ready[0];
          lvl = level[0];
          if (int'(lvl) > maxlvl) maxlvl = int'(lvl);
          if (rdy !== (lvl != 5'd16)) rdy_bad = 1'b1;
          @(negedge clk);
          cyc++;
          if (rdy) begin
            exp_q.push_back(w);
            sent++;
            w = 8'($urandom);
          end
        end
        valid[0] = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (txd[0] !== 1'b0 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        if (t >= 3000) begin
          compared++;
          mismatched++;
          $display("FAIL burst_start: got no start bit, required one");
        end else begin
          for (int i = 0; i < 20; i++) begin
            logic [7:0] w;
            if (exp_q.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL burst_order: frame %0d got line activity, required no word pending", i);
              break;
            end
            w = exp_q.pop_front();
            check_frame(0, w, "burst_frame", 1'b0);
          end
        end
      end
    join
    compared++;
    if (maxlvl != 16) begin
      mismatched++;
      $display("FAIL burst_max_level: got %0d required 16", maxlvl);
    end
    compared++;
    if (rdy_bad) begin
      mismatched++;
      $display("FAIL burst_ready: got ready inconsistent with level, required ready = (level != 16)");
    end
    compared++;
    if (busy[0] !== 1'b0 || level[0] !== 5'd0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL burst_end: got busy=%b level=%0d leftover=%0d required 0 0 0",
               busy[0], level[0], exp_q.size());
    end
  endtask

  task automatic test_push_on_pop();
    for (int r = 0; r < 3; r++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      valid[0] = 1'b1;
      data[0]  = a;
      @(negedge clk);
      data[0]  = b;
      compared++;
      if (level[0] !== 5'd1) begin
        mismatched++;
        $display("FAIL pushpop_pre: got level=%0d required 1", level[0]);
      end
      @(negedge clk);
      valid[0] = 1'b0;
      compared++;
      if (level[0] !== 5'd1) begin
        mismatched++;
        $display("FAIL pushpop_level: got level=%0d required 1", level[0]);
      end
      check_frame(0, a, "pushpop_first", 1'b1);
      check_frame(0, b, "pushpop_second", 1'b0);
      compared++;
      if (busy[0] !== 1'b0 || level[0] !== 5'd0) begin
        mismatched++;
        $display("FAIL pushpop_end: got busy=%b level=%0d required 0 0", busy[0], level[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    bit stray;
    push_word(0, 8'h00);
    push_word(0, 8'($urandom));
    push_word(0, 8'($urandom));
    t = 0;
    while (txd[0] !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (BPS + 3 * BPS + 4) @(negedge clk);
    compared++;
    if (txd[0] !== 1'b0 || level[0] !== 5'd2) begin
      mismatched++;
      $display("FAIL midframe_pre: got txd=%b level=%0d required 0 2", txd[0], level[0]);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (txd[0] !== 1'b1 || level[0] !== 5'd0 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL midframe_reset: got txd=%b level=%0d ready=%b busy=%b required 1 0 1 0",
               txd[0], level[0], ready[0], busy[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) stray = 1'b1;
    end
    compared++;
    if (stray) begin
      mismatched++;
      $display("FAIL midframe_stray: got line activity after reset, required idle high");
    end
    push_word(0, 8'h3C);
    check_frame(0, 8'h3C, "after_reset_3c", 1'b1);
    compared++;
    if (busy[0] !== 1'b0 || level[0] !== 5'd0) begin
      mismatched++;
      $display("FAIL after_reset_end: got busy=%b level=%0d required 0 0", busy[0], level[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid[k] = 1'b0;
      data[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_parity();
    test_short_two_stop();
    test_burst();
    test_push_on_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
